// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller.
// Blank guard, then drive each slot; snapshot taken once per frame.
module seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [3:0]  hex_out,
  output logic [3:0]  an,
  output logic        dp,
  output logic [1:0]  digit_sel,
  output logic        frame_tick
);

  localparam int MAXC =
    (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW = (MAXC > 2) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] RD_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BL_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {
    BLANK,
    DRIVE
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    sel, sel_n;
  logic [15:0]   snap, snap_n;
  logic          ft, ft_n;
  logic [3:0]    nib;
  logic          z1, z2, z3;
  logic          dark;

  // State, counter, slot, snapshot and frame pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BLANK;
      cnt   <= '0;
      sel   <= 2'd0;
      snap  <= 16'h0000;
      ft    <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sel   <= sel_n;
      snap  <= snap_n;
      ft    <= ft_n;
    end
  end

  // Next-state logic; everything freezes while en is low
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel;
    snap_n  = snap;
    ft_n    = 1'b0;
    if (en) begin
      if (state == BLANK && sel == 2'd0 && cnt == '0)
        snap_n = digits;
      unique case (state)
        BLANK: begin
          if (cnt == BL_LAST) begin
            state_n = DRIVE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt == RD_LAST) begin
            state_n = BLANK;
            cnt_n   = '0;
            sel_n   = sel + 2'd1;
            ft_n    = (sel == 2'd3);
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = BLANK;
      endcase
    end
  end

  // Leading-zero detection over the snapshot, from the top digit down
  always_comb begin
    z3   = (snap[15:12] == 4'h0);
    z2   = z3 && (snap[11:8] == 4'h0);
    z1   = z2 && (snap[7:4] == 4'h0);
    dark = 1'b0;
    unique case (sel)
      2'd1:    dark = blank_lz && z1;
      2'd2:    dark = blank_lz && z2;
      2'd3:    dark = blank_lz && z3;
      default: dark = 1'b0;
    endcase
  end

  // Output decode from registered state
  always_comb begin
    nib = snap[{sel, 2'b00} +: 4];
    an  = 4'b1111;
    dp  = 1'b1;
    if (en && state == DRIVE && !dark) begin
      an[sel] = 1'b0;
      dp      = ~dp_mask[sel];
    end
    hex_out    = nib;
    digit_sel  = sel;
    frame_tick = ft & en;
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed per-cycle expectations
// pushed into a queue, checked by an independent monitor.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic [3:0]  hex_out;
  logic [3:0]  an;
  logic        dp;
  logic [1:0]  digit_sel;
  logic        frame_tick;

  typedef struct packed {
    logic [3:0] an;
    logic       dp;
    logic [3:0] hex;
    logic [1:0] sel;
    logic       ft;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_cyc  = 0;

  seg_scan_ctrl #(
    .REFRESH_DIV (4),
    .BLANK_CYCLES(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .digits    (digits),
    .dp_mask   (dp_mask),
    .blank_lz  (blank_lz),
    .hex_out   (hex_out),
    .an        (an),
    .dp        (dp),
    .digit_sel (digit_sel),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Monitor: compare every queued expectation against the outputs
  always begin
    @(negedge clk);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (an !== e.an || dp !== e.dp || hex_out !== e.hex ||
          digit_sel !== e.sel || frame_tick !== e.ft) begin
        n_fail++;
        $display("FAIL cyc%0d got an=%b dp=%b hex=%h sel=%0d ft=%b want an=%b dp=%b hex=%h sel=%0d ft=%b",
                 n_cyc, an, dp, hex_out, digit_sel, frame_tick,
                 e.an, e.dp, e.hex, e.sel, e.ft);
      end
      n_cyc++;
    end
  end

  task automatic step(input logic [3:0] a, input logic d,
                      input logic [3:0] h, input logic [1:0] s,
                      input logic f);
    exp_t e;
    e.an  = a;
    e.dp  = d;
    e.hex = h;
    e.sel = s;
    e.ft  = f;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic drv(input int n, input logic [3:0] a,
                     input logic d, input logic [3:0] h,
                     input logic [1:0] s);
    repeat (n) step(a, d, h, s, 1'b0);
  endtask

  // One slot: a blank cycle then four drive cycles
  task automatic slot(input logic [1:0] s, input logic [3:0] hb,
                      input logic [3:0] hd, input logic lit,
                      input logic dpd, input logic f);
    logic [3:0] a;
    a = lit ? ~(4'b0001 << s) : 4'b1111;
    step(4'b1111, 1'b1, hb, s, f);
    drv(4, a, lit ? dpd : 1'b1, hd, s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    en       = 1'b1;
    digits   = 16'h1234;
    dp_mask  = 4'b0000;
    blank_lz = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    // frame A: reset state is the slot-0 blank; digits change in slot 1
    slot(2'd0, 4'h0, 4'h4, 1'b1, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 4'h3, 2'd1, 1'b0);
    drv(2, 4'b1101, 1'b1, 4'h3, 2'd1);
    digits = 16'h5678;
    drv(2, 4'b1101, 1'b1, 4'h3, 2'd1);
    slot(2'd2, 4'h2, 4'h2, 1'b1, 1'b1, 1'b0);
    slot(2'd3, 4'h1, 4'h1, 1'b1, 1'b1, 1'b0);
    // frame B: new snapshot
    slot(2'd0, 4'h4, 4'h8, 1'b1, 1'b1, 1'b1);
    slot(2'd1, 4'h7, 4'h7, 1'b1, 1'b1, 1'b0);
    slot(2'd2, 4'h6, 4'h6, 1'b1, 1'b1, 1'b0);
    slot(2'd3, 4'h5, 4'h5, 1'b1, 1'b1, 1'b0);
    // frame C: decimal point on slot 2
    dp_mask = 4'b0100;
    slot(2'd0, 4'h8, 4'h8, 1'b1, 1'b1, 1'b1);
    digits = 16'h0050;
    slot(2'd1, 4'h7, 4'h7, 1'b1, 1'b1, 1'b0);
    slot(2'd2, 4'h6, 4'h6, 1'b1, 1'b0, 1'b0);
    slot(2'd3, 4'h5, 4'h5, 1'b1, 1'b1, 1'b0);
    // frame D: leading-zero blanking of 0050, dp_mask cannot override
    dp_mask  = 4'b1101;
    blank_lz = 1'b1;
    slot(2'd0, 4'h8, 4'h0, 1'b1, 1'b0, 1'b1);
    slot(2'd1, 4'h5, 4'h5, 1'b1, 1'b1, 1'b0);
    digits = 16'h0000;
    slot(2'd2, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    slot(2'd3, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    // frame E: all zero, only slot 0 lit
    dp_mask = 4'b0000;
    slot(2'd0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1);
    slot(2'd1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    slot(2'd2, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    slot(2'd3, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    digits   = 16'h1234;
    blank_lz = 1'b0;
    // frame F: en gap of 7 cycles in slot 2 drive
    dp_mask = 4'b0100;
    slot(2'd0, 4'h0, 4'h4, 1'b1, 1'b1, 1'b1);
    slot(2'd1, 4'h3, 4'h3, 1'b1, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 4'h2, 2'd2, 1'b0);
    drv(2, 4'b1011, 1'b0, 4'h2, 2'd2);
    en = 1'b0;
    drv(7, 4'b1111, 1'b1, 4'h2, 2'd2);
    en = 1'b1;
    drv(2, 4'b1011, 1'b0, 4'h2, 2'd2);
    slot(2'd3, 4'h1, 4'h1, 1'b1, 1'b1, 1'b0);
    // frame G: reset mid slot 3 drive, nibbles above 9 pass through
    dp_mask = 4'b0000;
    slot(2'd0, 4'h4, 4'h4, 1'b1, 1'b1, 1'b1);
    slot(2'd1, 4'h3, 4'h3, 1'b1, 1'b1, 1'b0);
    slot(2'd2, 4'h2, 4'h2, 1'b1, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 4'h1, 2'd3, 1'b0);
    drv(2, 4'b0111, 1'b1, 4'h1, 2'd3);
    reset  = 1'b1;
    digits = 16'h5A7F;
    drv(1, 4'b0111, 1'b1, 4'h1, 2'd3);
    reset = 1'b0;
    slot(2'd0, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0);
    slot(2'd1, 4'h7, 4'h7, 1'b1, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 4'hA, 2'd2, 1'b0);
    #3;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
